// File: rtl/mem_init_frontend.sv
// mem_init_frontend: the only driver of a sync-read register memory.
// After reset it holds the memory in reset for two cycles, clears every word to
// INIT_VALUE with a one-word-per-cycle write sweep, then passes client write and
// read requests through to the memory and returns read data one cycle later.
//
// Optional feature: define MEM_INIT_FRONTEND_BYPASS_EN so that a same-cycle write
// and read to one address returns the new data. Without it the old word is returned.
//
// Ports
//   clk, resetn                      clock, async active-low reset
//   init_req                         restart the clear sweep (READY only)
//   wr_valid/wr_ready/wr_addr/wr_data  client write channel
//   rd_valid/rd_ready/rd_addr        client read request channel
//   rsp_valid/rsp_data               read response, one cycle after accept
//   init_done                        high while client traffic is accepted
//   mem_resetn, mem_wen, mem_waddr, mem_wdata, mem_raddr, mem_rdata  memory side
module mem_init_frontend #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  init_req,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  init_done,
    output logic                  mem_resetn,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W    = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_HOLD  = 2'd0,
        S_CLEAR = 2'd1,
        S_READY = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_hold_cnt;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_mem_resetn;
    logic                  r_rsp_valid;
    logic [ADDR_WIDTH-1:0] r_raddr;
    logic                  w_ready;
    logic                  w_wr_acc;
    logic                  w_rd_acc;

    assign w_wr_acc = w_ready & wr_valid;
    assign w_rd_acc = w_ready & rd_valid;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_HOLD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_HOLD:  if (r_hold_cnt)        w_state_nxt = S_CLEAR;
            S_CLEAR: if (r_cnt == CNT_LAST) w_state_nxt = S_READY;
            S_READY: if (init_req)          w_state_nxt = S_CLEAR;
            default:                        w_state_nxt = S_HOLD;
        endcase
    end

    // Output logic: sweep writes in CLEAR, client pass-through in READY
    always_comb begin
        w_ready   = 1'b0;
        mem_wen   = 1'b0;
        mem_waddr = r_cnt[ADDR_WIDTH-1:0];
        mem_wdata = INIT_VALUE;
        mem_raddr = r_raddr;
        case (r_state)
            S_CLEAR: begin
                mem_wen = 1'b1;
            end
            S_READY: begin
                w_ready   = 1'b1;
                mem_wen   = wr_valid;
                mem_waddr = wr_addr;
                mem_wdata = wr_data;
                mem_raddr = rd_addr;
            end
            default: ;
        endcase
    end

    // Hold/sweep counters, memory reset, response valid and last read address
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hold_cnt   <= 1'b0;
            r_cnt        <= '0;
            r_mem_resetn <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_raddr      <= '0;
        end else begin
            if (r_state == S_HOLD) begin
                r_hold_cnt <= 1'b1;
                // Second HOLD cycle: memory leaves reset together with the state change
                if (r_hold_cnt) begin
                    r_mem_resetn <= 1'b1;
                end
            end
            if (r_state == S_CLEAR && r_cnt != CNT_LAST) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
            r_rsp_valid <= w_rd_acc;
            if (w_ready) begin
                r_raddr <= rd_addr;
            end
        end
    end

`ifdef MEM_INIT_FRONTEND_BYPASS_EN
    logic                  r_byp;
    logic [DATA_WIDTH-1:0] r_byp_data;

    // Same-cycle write+read to one address: answer with the written data
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_byp      <= 1'b0;
            r_byp_data <= '0;
        end else begin
            r_byp <= w_wr_acc & w_rd_acc & (wr_addr == rd_addr);
            if (w_wr_acc & w_rd_acc & (wr_addr == rd_addr)) begin
                r_byp_data <= wr_data;
            end
        end
    end

    assign rsp_data = r_byp ? r_byp_data : mem_rdata;
`else
    logic w_unused_wr_acc;
    assign w_unused_wr_acc = w_wr_acc;
    assign rsp_data = mem_rdata;
`endif

    assign wr_ready   = w_ready;
    assign rd_ready   = w_ready;
    assign init_done  = w_ready;
    assign rsp_valid  = r_rsp_valid;
    assign mem_resetn = r_mem_resetn;

endmodule

// File: tb/tb_mem_init_frontend.sv
// tb_mem_init_frontend: directed bench for mem_init_frontend with a memory model
// attached to the memory port and a timeline-based reference model that checks
// every cycle. Inputs change on the falling edge; outputs are sampled mid-low-phase.
module tb_mem_init_frontend;

    logic        clk;
    logic        resetn;
    logic        init_req;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [4:0]  rd_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        init_done;
    logic        mem_resetn;
    logic        mem_wen;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic [4:0]  mem_raddr;
    logic [31:0] mem_rdata;

    int n_total = 0;
    int n_pass  = 0;

    mem_init_frontend #(
        .ADDR_WIDTH (5),
        .DATA_WIDTH (32),
        .INIT_VALUE (32'h0)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .init_req   (init_req),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_addr    (rd_addr),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .init_done  (init_done),
        .mem_resetn (mem_resetn),
        .mem_wen    (mem_wen),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 32x32 sync-read, read-before-write register memory
    logic [31:0] bmem [32];
    always @(posedge clk) begin
        if (!mem_resetn) mem_rdata <= 32'h0;
        else             mem_rdata <= bmem[mem_raddr];
        if (mem_wen) bmem[mem_waddr] <= mem_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: m_t counts cycles since reset release (0,1 hold; 2..33 sweep
    // of address m_t-2; 34 and on ready). init_req in ready jumps back to 2.
    logic [31:0] m_mem [32];
    int          m_t = 0;
    bit          m_pend = 0;
    logic [31:0] m_pend_data = 32'h0;
    bit          m_raddr_ok = 0;
    logic [4:0]  m_raddr = 5'd0;

    initial begin : compare
        bit e_ready;
        bit e_clear;
        forever begin
            @(negedge clk);
            #2;
            if (!resetn) begin
                chk("rst_mem_resetn", 32'(mem_resetn), 32'd0);
                chk("rst_mem_wen",    32'(mem_wen),    32'd0);
                chk("rst_wr_ready",   32'(wr_ready),   32'd0);
                chk("rst_rd_ready",   32'(rd_ready),   32'd0);
                chk("rst_init_done",  32'(init_done),  32'd0);
                chk("rst_rsp_valid",  32'(rsp_valid),  32'd0);
                m_t        = 0;
                m_pend     = 0;
                m_raddr_ok = 0;
            end else begin
                e_ready = (m_t >= 34);
                e_clear = (m_t >= 2) && (m_t < 34);
                chk("mem_resetn", 32'(mem_resetn), 32'(m_t >= 2));
                chk("wr_ready",   32'(wr_ready),   32'(e_ready));
                chk("rd_ready",   32'(rd_ready),   32'(e_ready));
                chk("init_done",  32'(init_done),  32'(e_ready));
                chk("mem_wen",    32'(mem_wen),    32'(e_ready ? wr_valid : e_clear));
                if (e_clear) begin
                    chk("sweep_waddr", 32'(mem_waddr), 32'(m_t - 2));
                    chk("sweep_wdata", mem_wdata, 32'h0);
                end
                if (e_ready) begin
                    if (wr_valid) begin
                        chk("pass_waddr", 32'(mem_waddr), 32'(wr_addr));
                        chk("pass_wdata", mem_wdata, wr_data);
                    end
                    chk("pass_raddr", 32'(mem_raddr), 32'(rd_addr));
                end else if (m_raddr_ok) begin
                    chk("held_raddr", 32'(mem_raddr), 32'(m_raddr));
                end
                chk("rsp_valid", 32'(rsp_valid), 32'(m_pend));
                if (m_pend) chk("rsp_data", rsp_data, m_pend_data);

                // Advance the model across the coming rising edge
                m_pend = 0;
                if (e_ready) begin
                    if (rd_valid) begin
                        m_pend      = 1;
                        m_pend_data = m_mem[rd_addr];
`ifdef MEM_INIT_FRONTEND_BYPASS_EN
                        if (wr_valid && wr_addr == rd_addr) m_pend_data = wr_data;
`endif
                    end
                    if (wr_valid) m_mem[wr_addr] = wr_data;
                    m_raddr    = rd_addr;
                    m_raddr_ok = 1;
                    m_t        = init_req ? 2 : 34;
                end else begin
                    if (e_clear) m_mem[5'(m_t - 2)] = 32'h0;
                    m_t++;
                end
            end
        end
    end

    task automatic do_cycle(input bit wv, input logic [4:0] wa, input logic [31:0] wd,
                            input bit rv, input logic [4:0] ra, input bit ir);
        @(negedge clk);
        wr_valid = wv;
        wr_addr  = wa;
        wr_data  = wd;
        rd_valid = rv;
        rd_addr  = ra;
        init_req = ir;
    endtask

    task automatic idle();
        do_cycle(0, 5'd0, 32'h0, 0, 5'd0, 0);
    endtask

    task automatic wait_ready();
        bit ok = 0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            #3;
            if (init_done) ok = 1;
        end
        if (!ok) chk("wait_ready_timeout", 32'd0, 32'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int          first_done;
        int          low_cnt;
        int          wen_cnt;
        bit          found;
        logic [31:0] exp3;

        resetn   = 1'b0;
        init_req = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = 5'd0;
        wr_data  = 32'h0;
        rd_valid = 1'b0;
        rd_addr  = 5'd0;
        repeat (3) @(negedge clk);

        // 1: release reset, two hold cycles, 32 sweep writes, ready on cycle 35
        resetn     = 1'b1;
        first_done = 0;
        low_cnt    = 0;
        wen_cnt    = 0;
        found      = 0;
        for (int k = 1; k <= 100 && !found; k++) begin
            if (k > 1) @(negedge clk);
            #3;
            if (!mem_resetn) low_cnt++;
            if (mem_wen) wen_cnt++;
            if (init_done) begin
                found      = 1;
                first_done = k;
            end
        end
        chk("t1_init_done_cycle", 32'(first_done), 32'd35);
        chk("t1_hold_cycles",     32'(low_cnt),    32'd2);
        chk("t1_sweep_writes",    32'(wen_cnt),    32'd32);

        // 2: write then read back
        do_cycle(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 0);
        do_cycle(0, 5'd0, 32'h0, 1, 5'd5, 0);
        idle();
        #3;
        chk("t2_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t2_rsp_data",  rsp_data, 32'hDEADBEEF);

        // 3: same-cycle write+read to one address
        do_cycle(1, 5'd7, 32'h11111111, 0, 5'd0, 0);
        do_cycle(1, 5'd7, 32'h22222222, 1, 5'd7, 0);
        do_cycle(0, 5'd0, 32'h0, 1, 5'd7, 0);
        #3;
`ifdef MEM_INIT_FRONTEND_BYPASS_EN
        exp3 = 32'h22222222;
`else
        exp3 = 32'h11111111;
`endif
        chk("t3_collide_rsp", rsp_data, exp3);
        idle();
        #3;
        chk("t3_followup_rsp", rsp_data, 32'h22222222);

        // Back-to-back reads of distinct words
        do_cycle(1, 5'd1, 32'h0000AAAA, 0, 5'd0, 0);
        do_cycle(1, 5'd2, 32'h0000BBBB, 1, 5'd1, 0);
        do_cycle(0, 5'd0, 32'h0, 1, 5'd2, 0);
        #3;
        chk("b2b_rsp1", rsp_data, 32'h0000AAAA);
        idle();
        #3;
        chk("b2b_rsp2", rsp_data, 32'h0000BBBB);

        // 4: init_req with a read in the same cycle, then the sweep erases data
        do_cycle(1, 5'd5, 32'hA5A5A5A5, 0, 5'd0, 0);
        do_cycle(0, 5'd0, 32'h0, 1, 5'd5, 1);
        idle();
        #3;
        chk("t4_pending_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t4_pending_rsp_data",  rsp_data, 32'hA5A5A5A5);
        low_cnt = 1;
        found   = 0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            #3;
            if (wr_ready) found = 1;
            else low_cnt++;
        end
        chk("t4_ready_low_cycles", 32'(low_cnt), 32'd32);
        do_cycle(0, 5'd0, 32'h0, 1, 5'd5, 0);
        idle();
        #3;
        chk("t4_cleared_rsp", rsp_data, 32'h00000000);

        // 6: write held during the sweep is accepted only on the first ready cycle
        do_cycle(0, 5'd0, 32'h0, 0, 5'd0, 1);
        do_cycle(1, 5'd3, 32'h12345678, 0, 5'd0, 0);
        found = 0;
        for (int k = 0; k < 100 && !found; k++) begin
            #3;
            if (wr_ready) found = 1;
            else @(negedge clk);
        end
        chk("t6_accepted", 32'(found), 32'd1);
        do_cycle(0, 5'd0, 32'h0, 1, 5'd3, 0);
        idle();
        #3;
        chk("t6_rsp", rsp_data, 32'h12345678);

        // 5: reset mid-sweep when the sweep is at address 12
        do_cycle(1, 5'd9, 32'hCAFEF00D, 0, 5'd0, 0);
        do_cycle(0, 5'd0, 32'h0, 0, 5'd0, 1);
        idle();
        found = 0;
        for (int k = 0; k < 100 && !found; k++) begin
            #3;
            if (mem_wen && mem_waddr == 5'd11) found = 1;
            else @(negedge clk);
        end
        chk("t5_reached_11", 32'(found), 32'd1);
        @(negedge clk);
        #1;
        chk("t5_pre_reset_waddr", 32'(mem_waddr), 32'd12);
        resetn = 1'b0;
        #2;
        chk("t5_rst_mem_resetn", 32'(mem_resetn), 32'd0);
        chk("t5_rst_mem_wen",    32'(mem_wen),    32'd0);
        chk("t5_rst_init_done",  32'(init_done),  32'd0);
        repeat (2) @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        #3;
        chk("t5_hold1", 32'(mem_resetn), 32'd0);
        @(negedge clk);
        #3;
        chk("t5_hold2", 32'(mem_resetn), 32'd0);
        @(negedge clk);
        #3;
        chk("t5_sweep_start_mem_resetn", 32'(mem_resetn), 32'd1);
        chk("t5_sweep_start_wen",        32'(mem_wen),    32'd1);
        chk("t5_sweep_start_addr",       32'(mem_waddr),  32'd0);
        wait_ready();
        do_cycle(0, 5'd0, 32'h0, 1, 5'd9, 0);
        idle();
        #3;
        chk("t5_cleared_rsp", rsp_data, 32'h00000000);

        repeat (2) idle();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
